// File: rtl/demux_2_buf.sv
// Registered 1-to-2 demultiplexer with a small FIFO per output.
// Define DEMUX_2_BUF_ORDER_EN for strict global ordering and the order_stall output.

module demux_2_buf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full_o  = (count_q == CountFull);
  assign valid_o = (count_q != '0);
  assign push    = push_i & ~full_o;
  assign pop     = valid_o & ready_i;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

module demux_2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             choose,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data
`ifdef DEMUX_2_BUF_ORDER_EN
  , output logic           order_stall
`endif
);

  logic a_full, b_full;
  logic base_ok, order_ok, accept;

  // Readiness only looks at registered full state, never at the sinks.
  assign base_ok  = choose ? ~b_full : ~a_full;
  assign in_ready = ~rst & base_ok & order_ok;
  assign accept   = in_valid & in_ready;

`ifdef DEMUX_2_BUF_ORDER_EN
  logic last_sel_q, last_sel_d;

  // A destination switch waits until the previous destination has drained.
  assign order_ok    = (choose == last_sel_q) | (last_sel_q ? ~b_valid : ~a_valid);
  assign order_stall = in_valid & ~rst & base_ok & ~order_ok;
  assign last_sel_d  = accept ? choose : last_sel_q;

  always_ff @(posedge clk) begin
    if (rst) last_sel_q <= 1'b0;
    else     last_sel_q <= last_sel_d;
  end
`else
  assign order_ok = 1'b1;
`endif

  demux_2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept & ~choose),
    .data_i  (in_data),
    .ready_i (a_ready),
    .valid_o (a_valid),
    .full_o  (a_full),
    .data_o  (a_data)
  );

  demux_2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept & choose),
    .data_i  (in_data),
    .ready_i (b_ready),
    .valid_o (b_valid),
    .full_o  (b_full),
    .data_o  (b_data)
  );

endmodule

// File: doc/demux_2_buf.md
Name: demux_2_buf

Overview:
- Registered 1-to-2 demultiplexer: one valid/ready input stream is routed to output A or output B by a per-transfer select bit.
- Each output has its own small FIFO, so a stalled sink does not block traffic already queued for the other sink.
- Used in the CPU datapath where one producer (e.g. load/store unit) feeds two consumers (data memory vs. MMIO/HI-LO path).

Parameters:
- WIDTH, 32, data width of input and both outputs.
- DEPTH, 2, entries per output FIFO; power of two, >=2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input transfer offered.
- in_ready  output  1  input transfer accepted this cycle when in_valid & in_ready.
- in_data  input  WIDTH  input payload.
- choose  input  1  destination: 0 routes to A, 1 routes to B.
- a_valid  output  1  A FIFO non-empty.
- a_ready  input  1  A sink consumes head when a_valid & a_ready.
- a_data  output  WIDTH  A FIFO head.
- b_valid  output  1  B FIFO non-empty.
- b_ready  input  1  B sink consumes head when b_valid & b_ready.
- b_data  output  WIDTH  B FIFO head.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset: both FIFOs empty, all pointers and counts 0, storage cleared. Outputs after reset: a_valid=0, b_valid=0, a_data=0, b_data=0. in_ready is 1 the cycle after reset deasserts.
- While rst is high, in_ready=0 and nothing is pushed or popped. Reset mid-operation discards all queued entries.
- Per-output FIFO state: wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH). full = (count==DEPTH). empty = (count==0).
- in_ready is combinational: choose ? ~b_full : ~a_full (base mode). It depends only on registered full state, never on a_ready/b_ready; there is no pass-through into a full FIFO.
- Push: in_valid & in_ready at a rising edge writes in_data into the FIFO selected by choose.
- Latency: 1 cycle. x_valid rises and x_data shows the word in the cycle after acceptance.
- Input rule: while in_valid=1 and not yet accepted, in_data and choose must stay stable. The bench checks this as an assertion.
- Pop: x_valid & x_ready at the edge advances rd_ptr.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance. This is legal when count>=1. A push with count==DEPTH is blocked by in_ready regardless of a concurrent pop.
- Throughput: one transfer per cycle sustained into either output while its sink is always ready.
- x_valid = ~empty. x_data = head entry when x_valid=1, forced to 0 when x_valid=0.
- FIFO order is preserved within each output. Relative order between A and B is not guaranteed in base mode.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Data integrity must hold across repeated wraps.

Optional Feature:
- Macro: DEMUX_2_BUF_ORDER_EN.
- Defined:
  - Strict global ordering. A 1-bit register last_sel records the destination of the most recent accepted word.
  - in_ready additionally requires (choose==last_sel) or the FIFO selected by last_sel being empty. A switch of destination therefore stalls until the previous destination has drained.
  - last_sel resets to 0.
  - Adds one output port, order_stall (1 bit): high when in_valid=1 and in_ready is low only because of the ordering rule.
- Not defined: base behaviour as described above. order_stall and last_sel do not exist.

Test Plan:
- Reset, then push 0x11111111 with choose=0, a_ready=1 -> next cycle a_valid=1, a_data=0x11111111; following cycle a_valid=0, a_data=0. b_valid stays 0 throughout.
- Hold a_ready=0 and push 0xA0, 0xA1 to A -> in_ready=0 for choose=0 after the 2nd push; a push of 0xB0 with choose=1 is still accepted. Releasing a_ready yields 0xA0 then 0xA1, in order.
- Streaming: 8 consecutive words 0..7 alternating choose, both sinks ready -> in_ready=1 every cycle. A receives 0,2,4,6 and B receives 1,3,5,7, each 1 cycle after acceptance. Covers pointer wrap.
- A FIFO full (DEPTH=2) with a_ready=1 and in_valid=1, choose=0 in the same cycle -> pop occurs, no push. Next cycle count=1 and in_ready=1.
- Assert rst while both FIFOs hold data -> next cycle a_valid=b_valid=0, a_data=b_data=0. A push afterward behaves like the post-reset case.
- With DEMUX_2_BUF_ORDER_EN, a_ready=0, A holding 0x5, push with choose=1 -> in_ready=0 and order_stall=1. Raising a_ready drains 0x5; the B push is accepted the cycle after A empties.
